fwd_hazard_unit: RTL



---
 rtl/fwd_pkg.sv | 22 ++
 rtl/fwd_hazard_unit_match.sv | 34 +++
 rtl/fwd_hazard_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the EX-stage forwarding and load-use hazard unit.
// History entries are sized for the default datapath (64-bit data, 5-bit register index).
package fwd_pkg;

    localparam int HIST_DATA_W   = 64;
    localparam int HIST_REG_AW   = 5;
    localparam int ZERO_REG_DFLT = 31;

    typedef struct packed {
        logic                   valid;
        logic                   regwrite;
        logic                   memread;
        logic [HIST_REG_AW-1:0] rd;
        logic [HIST_DATA_W-1:0] data;
    } hist_entry_t;

    // Select code 0 means register file; codes 1..depth name history entries.
    function automatic int sel_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Priority matcher for one EX operand: the youngest valid producer of the
// source register wins; the hardwired-zero register is never forwarded.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int REG_AW    = 5,
    parameter int ZERO_REG  = ZERO_REG_DFLT,
    parameter int FWD_DEPTH = 2,
    parameter int SEL_W     = sel_width(FWD_DEPTH)
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic [DATA_W-1:0] i_opnd,
    input  hist_entry_t       i_hist [FWD_DEPTH],
    output logic [SEL_W-1:0]  o_sel,
    output logic [DATA_W-1:0] o_fwd
);

    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

    // Walk oldest to youngest so the lowest matching index is the last assignment.
    always_comb begin
        o_sel = '0;
        o_fwd = i_opnd;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (i_hist[k].valid && i_hist[k].regwrite &&
                (REG_AW'(i_hist[k].rd) == i_rs) && (i_rs != ZERO_IDX)) begin
                o_sel = SEL_W'(k + 1);
                o_fwd = DATA_W'(i_hist[k].data);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding unit with its own in-flight destination history,
// a one-shot load-use stall FSM, a saturating stall counter and a sticky hazard flag.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int REG_AW    = 5,
    parameter int ZERO_REG  = ZERO_REG_DFLT,
    parameter int FWD_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ex_valid,
    input  logic [REG_AW-1:0]               ex_rs_a,
    input  logic [REG_AW-1:0]               ex_rs_b,
    input  logic [DATA_W-1:0]               ex_opnd_a,
    input  logic [DATA_W-1:0]               ex_opnd_b,
    input  logic [REG_AW-1:0]               ex_rd,
    input  logic                            ex_regwrite,
    input  logic                            ex_memread,
    input  logic [DATA_W-1:0]               ex_result,
    input  logic [DATA_W-1:0]               mem_rdata,
    input  logic                            id_valid,
    input  logic [REG_AW-1:0]               id_rs_a,
    input  logic [REG_AW-1:0]               id_rs_b,
    input  logic                            flush,
    output logic [DATA_W-1:0]               fwd_a,
    output logic [DATA_W-1:0]               fwd_b,
    output logic [sel_width(FWD_DEPTH)-1:0] sel_a,
    output logic [sel_width(FWD_DEPTH)-1:0] sel_b,
    output logic                            stall_id,
    output logic                            hazard_err,
    output logic [CNT_W-1:0]                stall_count
);

    localparam int                SEL_W    = sel_width(FWD_DEPTH);
    localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

    typedef enum logic {ST_IDLE, ST_STALL} state_t;

    state_t           r_state;
    hist_entry_t      r_hist [FWD_DEPTH];
    logic [CNT_W-1:0] r_stall_count;
    logic             r_hazard_err;

    hist_entry_t      w_hist_in;
    logic             w_lu;
    logic             w_stall;
    logic             w_load_hit_a;
    logic             w_load_hit_b;

    // A load in EX whose destination is read by the instruction in ID.
    assign w_lu = id_valid & ex_valid & ex_memread & ex_regwrite &
                  (ex_rd != ZERO_IDX) & ((ex_rd == id_rs_a) | (ex_rd == id_rs_b));
    assign w_stall = w_lu & (r_state == ST_IDLE) & ~flush & ~reset;

    always_comb begin
        w_hist_in.valid    = ex_valid & ~flush;
        w_hist_in.regwrite = ex_regwrite;
        w_hist_in.memread  = ex_memread;
        w_hist_in.rd       = HIST_REG_AW'(ex_rd);
        w_hist_in.data     = HIST_DATA_W'(ex_result);
    end

    // Payload shifts freely; only the valid bits are cleared by reset.
    always_ff @(posedge clk) begin
        r_hist[0] <= w_hist_in;
        for (int k = 1; k < FWD_DEPTH; k++) begin
            r_hist[k] <= r_hist[k-1];
            if (k == 1 && r_hist[0].memread) begin
                r_hist[k].data <= HIST_DATA_W'(mem_rdata);
            end
        end
        if (reset) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                r_hist[k].valid <= 1'b0;
            end
        end
    end

    fwd_match #(
        .DATA_W    (DATA_W),
        .REG_AW    (REG_AW),
        .ZERO_REG  (ZERO_REG),
        .FWD_DEPTH (FWD_DEPTH),
        .SEL_W     (SEL_W)
    ) u_match_a (
        .i_rs   (ex_rs_a),
        .i_opnd (ex_opnd_a),
        .i_hist (r_hist),
        .o_sel  (sel_a),
        .o_fwd  (fwd_a)
    );

    fwd_match #(
        .DATA_W    (DATA_W),
        .REG_AW    (REG_AW),
        .ZERO_REG  (ZERO_REG),
        .FWD_DEPTH (FWD_DEPTH),
        .SEL_W     (SEL_W)
    ) u_match_b (
        .i_rs   (ex_rs_b),
        .i_opnd (ex_opnd_b),
        .i_hist (r_hist),
        .o_sel  (sel_b),
        .o_fwd  (fwd_b)
    );

    // Winning entry is a load still in MEM: its data is the address, not the loaded value.
    assign w_load_hit_a = (sel_a == SEL_W'(1)) & r_hist[0].memread;
    assign w_load_hit_b = (sel_b == SEL_W'(1)) & r_hist[0].memread;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_stall_count <= '0;
            r_hazard_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE:  r_state <= w_stall ? ST_STALL : ST_IDLE;
                ST_STALL: r_state <= ST_IDLE;
            endcase
            if (w_stall && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + CNT_W'(1);
            end
            if (ex_valid && (w_load_hit_a || w_load_hit_b)) begin
                r_hazard_err <= 1'b1;
            end
        end
    end

    assign stall_id    = w_stall;
    assign hazard_err  = r_hazard_err;
    assign stall_count = r_stall_count;

endmodule
